// File: rtl/button_pkg.sv
// button_pkg: FSM state encoding, default timing and shared helpers
// for button_event_decoder and anything reusing tick_prescaler.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG       = 3'd3,
    ST_DB_RELEASE = 3'd4
  } btn_state_t;

  localparam int CLK_HZ_DEFAULT = 27_000_000;
  localparam int MS_TICK_DIV    = CLK_HZ_DEFAULT / 1000;

  function automatic logic timed(btn_state_t s);
    return s inside {ST_DB_PRESS, ST_PRESSED, ST_DB_RELEASE};
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: raw pin in, conditioned button events out.
// master = decoder side, slave = pin driver / event consumer side.
interface button_event_decoder_if;

  logic button;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic toggle;

  modport master (
    input  button,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output toggle
  );

  modport slave (
    output button,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  toggle
  );

endinterface

// File: rtl/button_event_decoder_tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1, tick pulses on wrap.
// Ports: clk, rst (async low), clr (restart interval), tick (out).
module tick_prescaler
  import button_pkg::*;
#(
  parameter int TICK_DIV = MS_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // a clear always wins so the new interval starts clean
  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: sync + debounce + short/long classify + toggle.
// Ports: clk, rst (async low), bus (master: button in, events out).
module button_event_decoder
  import button_pkg::*;
#(
  parameter int TICK_DIV       = MS_TICK_DIV,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int ACTIVE_LOW     = 1
) (
  input logic                          clk,
  input logic                          rst,
  button_event_decoder_if.master       bus
);

  localparam logic REL = (ACTIVE_LOW != 0);
  localparam int   TW  = $clog2(LONG_TICKS + 1);
  localparam logic [TW-1:0] DB_T = TW'(DEBOUNCE_TICKS);
  localparam logic [TW-1:0] LG_T = TW'(LONG_TICKS);

  logic s1;
  logic s2;
  logic p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= REL;
      s2 <= REL;
    end else begin
      s1 <= bus.button;
      s2 <= s1;
    end
  end

  assign p = s2 ^ REL;

  btn_state_t    state;
  btn_state_t    nxt;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic          chg;
  logic          was_long;
  logic          level_q;
  logic          tog_q;
  logic          press;
  logic          rel;
  logic          lng;

  always_comb begin
    nxt   = state;
    press = 1'b0;
    rel   = 1'b0;
    lng   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (p) nxt = ST_DB_PRESS;
      end
      ST_DB_PRESS: begin
        if (!p) begin
          nxt = ST_IDLE;
        end else if (tcnt == DB_T) begin
          nxt   = ST_PRESSED;
          press = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!p) begin
          nxt = ST_DB_RELEASE;
        end else if (tcnt == LG_T) begin
          nxt = ST_LONG;
          lng = 1'b1;
        end
      end
      ST_LONG: begin
        if (!p) nxt = ST_DB_RELEASE;
      end
      ST_DB_RELEASE: begin
        if (p) begin
          nxt = was_long ? ST_LONG : ST_PRESSED;
        end else if (tcnt == DB_T) begin
          nxt = ST_IDLE;
          rel = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // every state change restarts both timers
  assign chg = (nxt != state);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (chg),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tcnt     <= '0;
      was_long <= 1'b0;
      level_q  <= 1'b0;
      tog_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (chg) begin
        tcnt <= '0;
      end else if (tick && timed(state)) begin
        tcnt <= tcnt + TW'(1);
      end
      if (press) begin
        level_q <= 1'b1;
        tog_q   <= ~tog_q;
      end
      if (lng) was_long <= 1'b1;
      if (rel) begin
        level_q  <= 1'b0;
        was_long <= 1'b0;
      end
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = rel;
  assign bus.short_press   = rel & ~was_long;
  assign bus.long_press    = lng;
  assign bus.toggle        = tog_q;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Input-side counterpart to the LED drive logic. It conditions the raw board push-button into clean, single-cycle events that LED and control logic consume directly, replacing direct use of the raw pin.
- Pipeline: 2-FF synchronizer, tick-based debounce FSM, short/long press classifier, press-toggle register.
- Sits between the board button pin and any LED/mode logic in the same clock domain.

Parameters:
- TICK_DIV, 27000, clock cycles per debounce tick (1 ms at 27 MHz); must be >= 2.
- DEBOUNCE_TICKS, 20, ticks the synchronized level must hold before a press or release is accepted; must be >= 1.
- LONG_TICKS, 1000, ticks of accepted hold before a press is classed as long; must be > DEBOUNCE_TICKS.
- ACTIVE_LOW, 1, 1 = button pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- button  in  1  raw, asynchronous, bouncing button pin
- btn_level  out  1  debounced pressed level, 1 = pressed
- press_pulse  out  1  one-cycle pulse on accepted press
- release_pulse  out  1  one-cycle pulse on accepted release
- short_press  out  1  one-cycle pulse, coincident with release_pulse, when the press never reached long
- long_press  out  1  one-cycle pulse when hold reaches LONG_TICKS
- toggle  out  1  inverts on every press_pulse

Behaviour:
- Reset: one clock; rst is asynchronous and active-low. While rst=0:
  - all outputs 0;
  - both synchronizer flops hold the released level;
  - FSM in IDLE; prescaler and tick counters at 0.
- Synchronizer: button passes through two flops, then is normalized by ACTIVE_LOW so that p=1 means pressed.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick for one cycle when it wraps.
  - Cleared to 0 on every FSM state change, so each timed state's interval starts exactly at state entry.
- Tick counter: cleared on every state change; increments on tick.
- FSM states: IDLE, DB_PRESS, PRESSED, LONG, DB_RELEASE.
  - IDLE: p=1 -> DB_PRESS.
  - DB_PRESS:
    - p=0 -> IDLE (bounce rejected, no output).
    - tick counter reaches DEBOUNCE_TICKS -> PRESSED; press_pulse=1 for 1 cycle; btn_level<=1; toggle inverts.
  - PRESSED:
    - p=0 -> DB_RELEASE.
    - tick counter reaches LONG_TICKS -> LONG; long_press=1 for 1 cycle; was_long flag <= 1.
  - LONG: p=0 -> DB_RELEASE.
  - DB_RELEASE:
    - p=1 -> PRESSED if was_long=0, else LONG. No pulses.
    - Returning to PRESSED restarts the hold count; a release glitch never produces a long_press.
    - tick counter reaches DEBOUNCE_TICKS -> IDLE; release_pulse=1; short_press=1 if was_long=0; btn_level<=0; was_long<=0.
- Latency: define N_DB = DEBOUNCE_TICKS*TICK_DIV. A raw level stable from edge k produces the corresponding pulse in the cycle after edge k+2+N_DB, i.e. 2 synchronizer edges + 1 FSM entry edge + N_DB.
- long_press arrives LONG_TICKS*TICK_DIV cycles after PRESSED entry.
- Pulse exclusivity:
  - press_pulse, release_pulse and long_press are never high in the same cycle.
  - short_press is only ever high together with release_pulse.
- Bounce: any p reversal inside a DB state resets timing. Continuous bouncing never yields an event.
- Reset mid-press: all state is lost. After rst rises with the button held, a full DB_PRESS interval is required before press_pulse.
- Counter widths: derived with $clog2 from TICK_DIV and LONG_TICKS. Comparisons use equality, and no counter wraps while in a timed state.

Decomposition:
- Shared package button_pkg: FSM state enum (3-bit encoding) and default timing constants (CLK_HZ_DEFAULT=27_000_000, MS_TICK_DIV).
- One natural sub-module: tick_prescaler (parameter TICK_DIV; inputs clk, rst, clr; output tick). The LED blink dividers reuse it.

Test Plan:
(Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, ACTIVE_LOW=1, so N_DB=12.)
1. Reset with button=1 held for 50 cycles -> all outputs 0. After release of rst, no pulses for 100 cycles.
2. Clean short press: button=0 from edge 10 for 30 cycles, then 1.
   - press_pulse after edge 24; btn_level=1; toggle=1.
   - release_pulse and short_press together 15 edges after the release edge; btn_level=0; long_press never asserted.
3. Bounce rejection: button toggles every 3 cycles for 60 cycles, then settles at 1 -> no pulses at all; btn_level stays 0.
4. Long press: button=0 held 100 cycles.
   - press_pulse at edge+15; long_press 40 cycles after press_pulse.
   - On release: release_pulse with short_press=0.
5. Release glitch: during PRESSED, button=1 for 5 cycles then 0 again -> no release_pulse. The hold timer restarts, and long_press comes 40 cycles after FSM re-entry to PRESSED.
6. Reset mid-press: assert rst during PRESSED with button held; release rst -> outputs 0. Then press_pulse 15 edges after rst release, toggle=1.
